// File: rtl/reg_busy_table_pkg.sv
// reg_busy_table_pkg: shared register-address and ROB-tag types for the rename-side busy table.
package reg_busy_table_pkg;
  localparam int NUM_ARCH_REGS = 32;
  localparam int ROB_TAG_W = 4;
  localparam logic [4:0] ZERO_REG = 5'd0;
  typedef logic [4:0] reg_addr_t;
  typedef logic [ROB_TAG_W-1:0] rob_tag_t;
endpackage

// File: rtl/reg_busy_table_if.sv
// reg_busy_table_if: alloc/writeback/flush/lookup bundle between rename and the busy table.
interface reg_busy_table_if
  import reg_busy_table_pkg::*;
#(
  parameter int TAG_W = ROB_TAG_W
);
  logic alloc_valid;
  reg_addr_t alloc_rd;
  logic [TAG_W-1:0] alloc_tag;
  logic wb_valid;
  reg_addr_t wb_rd;
  logic [TAG_W-1:0] wb_tag;
  logic flush;
  reg_addr_t rs1_addr;
  reg_addr_t rs2_addr;
  logic rs1_ready;
  logic rs2_ready;
  logic [TAG_W-1:0] rs1_tag;
  logic [TAG_W-1:0] rs2_tag;
  logic [31:0] busy_vec;
  modport master (
    output alloc_valid, alloc_rd, alloc_tag, wb_valid, wb_rd, wb_tag, flush, rs1_addr, rs2_addr,
    input rs1_ready, rs2_ready, rs1_tag, rs2_tag, busy_vec
  );
  modport slave (
    input alloc_valid, alloc_rd, alloc_tag, wb_valid, wb_rd, wb_tag, flush, rs1_addr, rs2_addr,
    output rs1_ready, rs2_ready, rs1_tag, rs2_tag, busy_vec
  );
endinterface

// File: rtl/reg_busy_lookup.sv
// reg_busy_lookup: one source-operand lookup (ready bit + producer tag) into the busy table.
// REG_BUSY_WB_BYPASS_EN adds a same-cycle writeback bypass on the ready bit.
module reg_busy_lookup
  import reg_busy_table_pkg::*;
#(
  parameter int NUM_REGS = NUM_ARCH_REGS,
  parameter int TAG_W = ROB_TAG_W
) (
  input reg_addr_t addr_i,
  input logic [NUM_REGS-1:0] busy_i,
  input logic [NUM_REGS-1:0][TAG_W-1:0] tag_i,
`ifdef REG_BUSY_WB_BYPASS_EN
  input logic wb_valid_i,
  input reg_addr_t wb_rd_i,
  input logic [TAG_W-1:0] wb_tag_i,
`endif
  output logic ready_o,
  output logic [TAG_W-1:0] tag_o
);
  assign tag_o = tag_i[addr_i];
`ifdef REG_BUSY_WB_BYPASS_EN
  // A non-busy entry is already ready, so the busy qualifier is folded into the OR.
  assign ready_o = !busy_i[addr_i] || (wb_valid_i && wb_rd_i == addr_i && wb_tag_i == tag_o);
`else
  assign ready_o = !busy_i[addr_i];
`endif
endmodule

// File: rtl/reg_busy_table.sv
// reg_busy_table: per-register busy bit and producer ROB tag with two rename lookup ports.
// Optional REG_BUSY_WB_BYPASS_EN enables same-cycle writeback bypass on rs*_ready.
module reg_busy_table
  import reg_busy_table_pkg::*;
#(
  parameter int NUM_REGS = NUM_ARCH_REGS,
  parameter int TAG_W = ROB_TAG_W
) (
  input logic clk,
  input logic reset,
  reg_busy_table_if.slave bus
);
  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [NUM_REGS-1:0][TAG_W-1:0] tag_q, tag_d;
  for (genvar r = 0; r < NUM_REGS; r++) begin : g_reg
    if (r == ZERO_REG) begin : g_zero
      assign busy_d[r] = 1'b0;
      assign tag_d[r] = tag_q[r];
    end else begin : g_arch
      logic alloc_hit, wb_hit;
      assign alloc_hit = !bus.flush && bus.alloc_valid && bus.alloc_rd == reg_addr_t'(r);
      assign wb_hit = bus.wb_valid && bus.wb_rd == reg_addr_t'(r) && tag_q[r] == bus.wb_tag;
      // Alloc overrides a same-cycle writeback; flush clears busy but keeps tags.
      assign busy_d[r] = !bus.flush && (alloc_hit || (busy_q[r] && !wb_hit));
      assign tag_d[r] = alloc_hit ? bus.alloc_tag : tag_q[r];
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q <= '0;
      tag_q <= '0;
    end else begin
      busy_q <= busy_d;
      tag_q <= tag_d;
    end
  end
  assign bus.busy_vec = busy_q;
  reg_busy_lookup #(.NUM_REGS(NUM_REGS), .TAG_W(TAG_W)) u_rs1 (
    .addr_i(bus.rs1_addr),
    .busy_i(busy_q),
    .tag_i(tag_q),
`ifdef REG_BUSY_WB_BYPASS_EN
    .wb_valid_i(bus.wb_valid),
    .wb_rd_i(bus.wb_rd),
    .wb_tag_i(bus.wb_tag),
`endif
    .ready_o(bus.rs1_ready),
    .tag_o(bus.rs1_tag)
  );
  reg_busy_lookup #(.NUM_REGS(NUM_REGS), .TAG_W(TAG_W)) u_rs2 (
    .addr_i(bus.rs2_addr),
    .busy_i(busy_q),
    .tag_i(tag_q),
`ifdef REG_BUSY_WB_BYPASS_EN
    .wb_valid_i(bus.wb_valid),
    .wb_rd_i(bus.wb_rd),
    .wb_tag_i(bus.wb_tag),
`endif
    .ready_o(bus.rs2_ready),
    .tag_o(bus.rs2_tag)
  );
endmodule

// File: tb/tb_reg_busy_table.sv
// tb_reg_busy_table: directed scenarios plus randomized traffic against a behavioural busy-table model.
module tb_reg_busy_table;
  import reg_busy_table_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b1;
  reg_busy_table_if bus();
  reg_busy_table dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
`ifdef REG_BUSY_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] m_busy = '0;
  rob_tag_t m_tag [32];
  function automatic logic exp_ready(reg_addr_t a);
    return !m_busy[a] || (BYP && bus.wb_valid && bus.wb_rd == a && bus.wb_tag == m_tag[a]);
  endfunction
  task automatic drive(logic av, reg_addr_t ar, rob_tag_t at, logic wv, reg_addr_t wr, rob_tag_t wt, logic fl);
    bus.alloc_valid = av;
    bus.alloc_rd = ar;
    bus.alloc_tag = at;
    bus.wb_valid = wv;
    bus.wb_rd = wr;
    bus.wb_tag = wt;
    bus.flush = fl;
  endtask
  task automatic tick();
    if (bus.flush) m_busy = '0;
    else begin
      if (bus.wb_valid && m_busy[bus.wb_rd] && m_tag[bus.wb_rd] == bus.wb_tag) m_busy[bus.wb_rd] = 1'b0;
      if (bus.alloc_valid && bus.alloc_rd != 5'd0) begin
        m_busy[bus.alloc_rd] = 1'b1;
        m_tag[bus.alloc_rd] = bus.alloc_tag;
      end
    end
    @(posedge clk);
    #1;
    drive(0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic test_reset();
    bus.rs1_addr = 5'd5;
    #1;
    n_cmp++; if (bus.busy_vec !== 32'h0) begin n_bad++; $display("FAIL reset_busy_vec: got %h want %h", bus.busy_vec, 32'h0); end
    n_cmp++; if (bus.rs1_ready !== 1'b1) begin n_bad++; $display("FAIL reset_rs1_ready: got %b want 1", bus.rs1_ready); end
    n_cmp++; if (bus.rs1_tag !== 4'd0) begin n_bad++; $display("FAIL reset_rs1_tag: got %0d want 0", bus.rs1_tag); end
    for (int i = 4; i < 8; i++) begin
      drive(1, reg_addr_t'(i), rob_tag_t'(i), 0, 0, 0, 0);
      tick();
    end
    n_cmp++; if (bus.busy_vec !== 32'h0000_00F0) begin n_bad++; $display("FAIL prereset_busy_vec: got %h want %h", bus.busy_vec, 32'hF0); end
    n_cmp++; if (bus.rs1_ready !== 1'b0) begin n_bad++; $display("FAIL prereset_rs1_ready: got %b want 0", bus.rs1_ready); end
    reset = 1'b1;
    #1;
    m_busy = '0;
    for (int i = 0; i < 32; i++) m_tag[i] = '0;
    n_cmp++; if (bus.busy_vec !== 32'h0) begin n_bad++; $display("FAIL async_reset_busy_vec: got %h want 0", bus.busy_vec); end
    n_cmp++; if (bus.rs1_ready !== 1'b1) begin n_bad++; $display("FAIL async_reset_rs1_ready: got %b want 1", bus.rs1_ready); end
    n_cmp++; if (bus.rs1_tag !== 4'd0) begin n_bad++; $display("FAIL async_reset_rs1_tag: got %0d want 0", bus.rs1_tag); end
    @(negedge clk);
    reset = 1'b0;
  endtask
  task automatic test_alloc_wb();
    drive(1, 7, 3, 0, 0, 0, 0);
    tick();
    bus.rs1_addr = 5'd7;
    #1;
    n_cmp++; if (bus.rs1_ready !== 1'b0) begin n_bad++; $display("FAIL alloc_rs1_ready: got %b want 0", bus.rs1_ready); end
    n_cmp++; if (bus.rs1_tag !== 4'd3) begin n_bad++; $display("FAIL alloc_rs1_tag: got %0d want 3", bus.rs1_tag); end
    n_cmp++; if (bus.busy_vec[7] !== 1'b1) begin n_bad++; $display("FAIL alloc_busy7: got %b want 1", bus.busy_vec[7]); end
    drive(0, 0, 0, 1, 7, 3, 0);
    tick();
    n_cmp++; if (bus.rs1_ready !== 1'b1) begin n_bad++; $display("FAIL wb_rs1_ready: got %b want 1", bus.rs1_ready); end
    n_cmp++; if (bus.busy_vec[7] !== 1'b0) begin n_bad++; $display("FAIL wb_busy7: got %b want 0", bus.busy_vec[7]); end
  endtask
  task automatic test_stale_wb();
    drive(1, 7, 3, 0, 0, 0, 0);
    tick();
    drive(1, 7, 9, 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 1, 7, 3, 0);
    tick();
    bus.rs1_addr = 5'd7;
    #1;
    n_cmp++; if (bus.rs1_ready !== 1'b0) begin n_bad++; $display("FAIL stale_rs1_ready: got %b want 0", bus.rs1_ready); end
    n_cmp++; if (bus.rs1_tag !== 4'd9) begin n_bad++; $display("FAIL stale_rs1_tag: got %0d want 9", bus.rs1_tag); end
    drive(0, 0, 0, 1, 7, 9, 0);
    tick();
    n_cmp++; if (bus.busy_vec[7] !== 1'b0) begin n_bad++; $display("FAIL fresh_wb_busy7: got %b want 0", bus.busy_vec[7]); end
    drive(0, 0, 0, 1, 8, 0, 0);
    tick();
    n_cmp++; if (bus.busy_vec !== m_busy) begin n_bad++; $display("FAIL idle_wb_busy_vec: got %h want %h", bus.busy_vec, m_busy); end
  endtask
  task automatic test_same_cycle();
    drive(1, 4, 2, 0, 0, 0, 0);
    tick();
    drive(1, 4, 5, 1, 4, 2, 0);
    tick();
    bus.rs2_addr = 5'd4;
    #1;
    n_cmp++; if (bus.rs2_ready !== 1'b0) begin n_bad++; $display("FAIL same_cycle_rs2_ready: got %b want 0", bus.rs2_ready); end
    n_cmp++; if (bus.rs2_tag !== 4'd5) begin n_bad++; $display("FAIL same_cycle_rs2_tag: got %0d want 5", bus.rs2_tag); end
  endtask
  task automatic test_zero_flush();
    drive(1, 0, 6, 0, 0, 0, 0);
    tick();
    bus.rs2_addr = 5'd0;
    #1;
    n_cmp++; if (bus.busy_vec[0] !== 1'b0) begin n_bad++; $display("FAIL zero_busy0: got %b want 0", bus.busy_vec[0]); end
    n_cmp++; if (bus.rs2_ready !== 1'b1) begin n_bad++; $display("FAIL zero_rs2_ready: got %b want 1", bus.rs2_ready); end
    drive(1, 10, 11, 0, 0, 0, 0);
    tick();
    drive(1, 9, 13, 0, 0, 0, 1);
    tick();
    bus.rs1_addr = 5'd10;
    bus.rs2_addr = 5'd9;
    #1;
    n_cmp++; if (bus.busy_vec !== 32'h0) begin n_bad++; $display("FAIL flush_busy_vec: got %h want 0", bus.busy_vec); end
    n_cmp++; if (bus.rs1_tag !== 4'd11) begin n_bad++; $display("FAIL flush_keeps_tag: got %0d want 11", bus.rs1_tag); end
    n_cmp++; if (bus.rs2_tag !== m_tag[9]) begin n_bad++; $display("FAIL flush_drops_alloc_tag: got %0d want %0d", bus.rs2_tag, m_tag[9]); end
  endtask
  task automatic test_bypass();
    drive(1, 12, 1, 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 1, 12, 1, 0);
    bus.rs1_addr = 5'd12;
    #1;
    n_cmp++; if (bus.rs1_ready !== BYP) begin n_bad++; $display("FAIL bypass_same_cycle: got %b want %b", bus.rs1_ready, BYP); end
    n_cmp++; if (bus.busy_vec[12] !== 1'b1) begin n_bad++; $display("FAIL bypass_busy_vec: got %b want 1", bus.busy_vec[12]); end
    tick();
    n_cmp++; if (bus.rs1_ready !== 1'b1) begin n_bad++; $display("FAIL bypass_next_cycle: got %b want 1", bus.rs1_ready); end
  endtask
  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      reg_addr_t wr = reg_addr_t'($urandom_range(0, 31));
      rob_tag_t wt = ($urandom_range(0, 1) == 1) ? m_tag[wr] : rob_tag_t'($urandom);
      drive($urandom_range(0, 9) < 6, reg_addr_t'($urandom_range(0, 31)), rob_tag_t'($urandom),
            $urandom_range(0, 9) < 7, wr, wt, $urandom_range(0, 39) == 0);
      bus.rs1_addr = ($urandom_range(0, 2) == 0) ? wr : reg_addr_t'($urandom_range(0, 31));
      bus.rs2_addr = reg_addr_t'($urandom_range(0, 31));
      #1;
      n_cmp++; if (bus.rs1_ready !== exp_ready(bus.rs1_addr)) begin n_bad++; $display("FAIL rand_rs1_ready[%0d] r%0d: got %b want %b", n, bus.rs1_addr, bus.rs1_ready, exp_ready(bus.rs1_addr)); end
      n_cmp++; if (bus.rs1_tag !== m_tag[bus.rs1_addr]) begin n_bad++; $display("FAIL rand_rs1_tag[%0d] r%0d: got %0d want %0d", n, bus.rs1_addr, bus.rs1_tag, m_tag[bus.rs1_addr]); end
      n_cmp++; if (bus.rs2_ready !== exp_ready(bus.rs2_addr)) begin n_bad++; $display("FAIL rand_rs2_ready[%0d] r%0d: got %b want %b", n, bus.rs2_addr, bus.rs2_ready, exp_ready(bus.rs2_addr)); end
      n_cmp++; if (bus.rs2_tag !== m_tag[bus.rs2_addr]) begin n_bad++; $display("FAIL rand_rs2_tag[%0d] r%0d: got %0d want %0d", n, bus.rs2_addr, bus.rs2_tag, m_tag[bus.rs2_addr]); end
      tick();
      n_cmp++; if (bus.busy_vec !== m_busy) begin n_bad++; $display("FAIL rand_busy_vec[%0d]: got %h want %h", n, bus.busy_vec, m_busy); end
    end
  endtask
  initial begin
    for (int i = 0; i < 32; i++) m_tag[i] = '0;
    drive(0, 0, 0, 0, 0, 0, 0);
    bus.rs1_addr = '0;
    bus.rs2_addr = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    test_reset();
    test_alloc_wb();
    test_stale_wb();
    test_same_cycle();
    test_zero_flush();
    test_bypass();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
